// File: rtl/vector_division_pkg.sv
// Shared sizing constants and FSM state type for the vector divider.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package vector_division_pkg;

  localparam int LANES = 4;
  localparam int WIDTH = 16;
  localparam int FRAC  = 8;
  // One quotient bit per DIVIDE cycle; equals WIDTH + FRAC at defaults.
  localparam int ITER  = 24;
  localparam int CNT_W = $clog2(ITER);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    FINISH = 2'd2
  } state_t;

endpackage

// File: rtl/sdiv_lane.sv
// One signed fixed-point divider lane: operand select, restoring iteration, sign/saturate.
// Latency: result valid on q after load + ITER step cycles; q is combinational from lane state.
// Backpressure: none; the parent FSM sequences load/step and samples q when done.
module sdiv_lane
  import vector_division_pkg::*;
#(
  parameter int WIDTH = vector_division_pkg::WIDTH,
  parameter int FRAC  = vector_division_pkg::FRAC,
  parameter int ITER  = vector_division_pkg::ITER
) (
  input  logic                    clk_100mhz,
  input  logic                    reset,
  input  logic                    load,
  input  logic                    step,
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  input  logic                    sel,
  output logic signed [WIDTH-1:0] q
);

  localparam logic signed [WIDTH-1:0] QMAX    = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] QMIN    = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [ITER-1:0]         POS_LIM = ITER'((64'd1 << (WIDTH-1)) - 64'd1);

  // Numerator/denominator are one bit wider so b-a never overflows.
  logic signed [WIDTH:0] n_s, d_s;
  logic        [WIDTH:0] n_abs, d_abs;

  // Lane state: quo starts as the shifted dividend and fills with quotient bits.
  logic [WIDTH:0]   dmag;
  logic [WIDTH:0]   rem;
  logic [ITER-1:0]  quo;
  logic             neg, nneg, nzero, dzero;

  logic [WIDTH+1:0] rem_sh, diff;
  logic             ge;
  logic [WIDTH:0]   rem_nx;

  // Select operands for the mode and take magnitudes.
  always_comb begin
    n_s   = sel ? ({b[WIDTH-1], b} - {a[WIDTH-1], a}) : {a[WIDTH-1], a};
    d_s   = sel ? {a[WIDTH-1], a} : {b[WIDTH-1], b};
    n_abs = n_s[WIDTH] ? (-n_s) : n_s;
    d_abs = d_s[WIDTH] ? (-d_s) : d_s;
  end

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    rem_sh = {rem, quo[ITER-1]};
    diff   = rem_sh - {1'b0, dmag};
    ge     = ~diff[WIDTH+1];
    rem_nx = ge ? diff[WIDTH:0] : rem_sh[WIDTH:0];
  end

  // Capture operands on load, then iterate one quotient bit per step.
  always_ff @(posedge clk_100mhz or posedge reset) begin
    if (reset) begin
      dmag  <= '0;
      rem   <= '0;
      quo   <= '0;
      neg   <= 1'b0;
      nneg  <= 1'b0;
      nzero <= 1'b0;
      dzero <= 1'b0;
    end else if (load) begin
      dmag  <= d_abs;
      rem   <= '0;
      quo   <= ITER'({n_abs, {FRAC{1'b0}}});
      neg   <= n_s[WIDTH] ^ d_s[WIDTH];
      nneg  <= n_s[WIDTH];
      nzero <= (n_s == '0);
      dzero <= (d_s == '0);
    end else if (step) begin
      rem   <= rem_nx;
      quo   <= {quo[ITER-2:0], ge};
    end
  end

  // Apply sign to the magnitude quotient, saturate, and handle divide by zero.
  always_comb begin
    q = '0;
    if (dzero) begin
      if (nzero)     q = '0;
      else if (nneg) q = QMIN;
      else           q = QMAX;
    end else if (neg) begin
      if (quo > POS_LIM) q = QMIN;
      else               q = -quo[WIDTH-1:0];
    end else begin
      if (quo > POS_LIM) q = QMAX;
      else               q = quo[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/vector_division.sv
// Lockstep multi-lane signed divider (ratio a/b or return (b-a)/a) in fixed point.
// Latency: 25 cycles from acceptance to the one-cycle ready pulse; next accept one cycle later.
// Backpressure: none; valid is only sampled in IDLE, requests while busy are dropped.
module vector_division
  import vector_division_pkg::*;
#(
  parameter int LANES = vector_division_pkg::LANES,
  parameter int WIDTH = vector_division_pkg::WIDTH,
  parameter int FRAC  = vector_division_pkg::FRAC
) (
  input  logic                    clk_100mhz,
  input  logic                    reset,
  input  logic                    valid,
  input  logic signed [WIDTH-1:0] a [0:LANES-1],
  input  logic signed [WIDTH-1:0] b [0:LANES-1],
  input  logic                    sel,
  output logic signed [WIDTH-1:0] c [0:LANES-1],
  output logic                    ready
);

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt;
  logic               load, step, finish;
  logic signed [WIDTH-1:0] lane_q [0:LANES-1];

  // Next-state and lane control decode.
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    step     = 1'b0;
    finish   = 1'b0;
    case (state)
      IDLE: begin
        if (valid) begin
          load     = 1'b1;
          state_nx = DIVIDE;
        end
      end
      DIVIDE: begin
        step = 1'b1;
        if (cnt == CNT_W'(ITER - 1)) state_nx = FINISH;
      end
      FINISH: begin
        finish   = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register and iteration counter shared by all lanes.
  always_ff @(posedge clk_100mhz or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      if (load)      cnt <= '0;
      else if (step) cnt <= cnt + 1'b1;
    end
  end

  // Publish all lane results together and pulse ready for one cycle.
  always_ff @(posedge clk_100mhz or posedge reset) begin
    if (reset) begin
      ready <= 1'b0;
      for (int i = 0; i < LANES; i++) c[i] <= '0;
    end else begin
      ready <= finish;
      if (finish) begin
        for (int i = 0; i < LANES; i++) c[i] <= lane_q[i];
      end
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    sdiv_lane #(
      .WIDTH (WIDTH),
      .FRAC  (FRAC),
      .ITER  (ITER)
    ) u_lane (
      .clk_100mhz (clk_100mhz),
      .reset      (reset),
      .load       (load),
      .step       (step),
      .a          (a[i]),
      .b          (b[i]),
      .sel        (sel),
      .q          (lane_q[i])
    );
  end

endmodule

// File: tb/tb_vector_division.sv
// Directed self-checking bench for vector_division.
// Latency: checks the 25-cycle request-to-ready timing and 26-cycle back-to-back spacing.
// Backpressure: exercises ignored valid while busy and reset abort.
module tb_vector_division;
  import vector_division_pkg::*;

  typedef logic signed [WIDTH-1:0] vec_t [0:LANES-1];

  logic clk_100mhz = 1'b0;
  logic reset;
  logic valid;
  logic sel;
  vec_t a, b, c;
  logic ready;

  int tests  = 0;
  int failed = 0;

  always #5 clk_100mhz = ~clk_100mhz;

  vector_division #(.LANES(LANES), .WIDTH(WIDTH), .FRAC(FRAC)) dut (
    .clk_100mhz (clk_100mhz),
    .reset      (reset),
    .valid      (valid),
    .a          (a),
    .b          (b),
    .sel        (sel),
    .c          (c),
    .ready      (ready)
  );

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_c(input string tag, input vec_t ec);
    for (int i = 0; i < LANES; i++)
      check($sformatf("%s c[%0d]", tag, i), c[i], ec[i]);
  endtask

  // Issue one request from IDLE, scramble inputs after acceptance, check timing and result.
  task automatic run_req(input string tag, input vec_t va, input vec_t vb,
                         input logic vs, input vec_t ec);
    int  lat;
    bit  seen;
    a = va; b = vb; sel = vs; valid = 1'b1;
    @(posedge clk_100mhz); #1;
    valid = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      a[i] = ~va[i];
      b[i] = 16'sd0;
    end
    sel  = ~vs;
    lat  = 0;
    seen = 0;
    while (!seen && lat < 40) begin
      @(posedge clk_100mhz); #1;
      lat++;
      if (ready) seen = 1;
    end
    check({tag, " latency"}, lat, 25);
    check_c(tag, ec);
    @(posedge clk_100mhz); #1;
    check({tag, " ready drop"}, {31'd0, ready}, 0);
  endtask

  vec_t va1, vb1, ec1, ec2, va3, vb3, ec3, va4, vb4, ec4, zero_v, first_c;
  int   gap, changes, cyc;
  bit   seen;

  initial begin
    va1 = '{100, 200, 300, 400};   vb1 = '{110, 210, 310, 410};
    ec1 = '{25, 12, 8, 6};         ec2 = '{232, 243, 247, 249};
    va3 = '{-512, 512, -512, 0};   vb3 = '{256, -256, -256, 7};
    ec3 = '{-512, -512, 512, 0};
    va4 = '{32767, -32768, 5, -5}; vb4 = '{1, 1, 0, 0};
    ec4 = '{32767, -32768, 32767, -32768};
    zero_v = '{0, 0, 0, 0};

    reset = 1'b1; valid = 1'b0; sel = 1'b0; a = zero_v; b = zero_v;
    repeat (3) @(posedge clk_100mhz);
    #1;
    check("reset ready", {31'd0, ready}, 0);
    check_c("reset", zero_v);
    reset = 1'b0;
    @(posedge clk_100mhz); #1;

    run_req("return", va1, vb1, 1'b1, ec1);
    run_req("ratio", va1, vb1, 1'b0, ec2);
    check_c("held", ec2);
    run_req("signs", va3, vb3, 1'b0, ec3);
    run_req("sat_dz", va4, vb4, 1'b0, ec4);

    // Back-to-back with valid held high: pulses 26 cycles apart, c stable between.
    a = va1; b = vb1; sel = 1'b1; valid = 1'b1;
    seen = 0; cyc = 0;
    while (!seen && cyc < 40) begin
      @(posedge clk_100mhz); #1;
      cyc++;
      if (ready) seen = 1;
    end
    check("b2b first pulse", {31'd0, seen}, 1);
    check_c("b2b first", ec1);
    first_c = c;
    a = va1; b = vb1; sel = 1'b0;
    gap = 0; changes = 0; seen = 0;
    while (!seen && gap < 60) begin
      @(posedge clk_100mhz); #1;
      gap++;
      if (ready) seen = 1;
      else if (c !== first_c) changes++;
    end
    valid = 1'b0;
    check("b2b gap", gap, 26);
    check("b2b c stable", changes, 0);
    check_c("b2b second", ec2);
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk_100mhz); #1;
      if (ready) seen = 1;
    end
    check("b2b stops", {31'd0, seen}, 0);

    // Reset during DIVIDE aborts with no pulse and clears c.
    a = va4; b = vb4; sel = 1'b0; valid = 1'b1;
    @(posedge clk_100mhz); #1;
    valid = 1'b0;
    repeat (10) @(posedge clk_100mhz);
    #1;
    reset = 1'b1;
    #1;
    check("abort ready", {31'd0, ready}, 0);
    check_c("abort", zero_v);
    repeat (2) @(posedge clk_100mhz);
    #1;
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk_100mhz); #1;
      if (ready) seen = 1;
    end
    check("abort no pulse", {31'd0, seen}, 0);
    check_c("abort idle", zero_v);
    run_req("after abort", va1, vb1, 1'b1, ec1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/vector_division.md
VECTOR_DIVISION -- requirements
Module: vector_division

Interface
REQ-001 Parameter LANES, default 4: number of element lanes.
REQ-002 Parameter WIDTH, default 16: element width in bits; all elements are signed two's complement.
REQ-003 Parameter FRAC, default 8: fractional bits of output c (signed Q8.8 at defaults).
REQ-004 clk_100mhz  input  1  sole clock, rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 valid  input  1  request; sampled only in IDLE.
REQ-007 a  input  LANES x WIDTH, signed, unpacked array [0:LANES-1]  operand A (old value).
REQ-008 b  input  LANES x WIDTH, signed, unpacked array [0:LANES-1]  operand B (new value).
REQ-009 sel  input  1  mode: 0 = ratio a/b; 1 = return (b-a)/a.
REQ-010 c  output  LANES x WIDTH, signed, unpacked array [0:LANES-1]  registered quotients, held until the next result.
REQ-011 ready  output  1  one-cycle pulse marking new c.

Function
REQ-012 The module SHALL use states IDLE -> DIVIDE -> FINISH -> IDLE.
REQ-013 In IDLE with valid=1 at edge E0, the module SHALL capture a, b and sel per lane and enter DIVIDE; later changes to a, b and sel SHALL NOT affect the operation in progress.
REQ-014 Per lane, the numerator N SHALL be a[i] when sel=0, or the 17-bit signed difference b[i]-a[i] when sel=1.
REQ-015 Per lane, the denominator D SHALL be b[i] when sel=0, or a[i] when sel=1.
REQ-016 Each lane SHALL compute q = trunc_toward_zero((N * 2^FRAC) / D) using an unsigned restoring divider on magnitudes.
REQ-017 The divider SHALL use a 24-bit dividend (|N| << FRAC), perform one quotient bit per cycle, and run exactly 24 DIVIDE cycles at edges E0+1 .. E0+24.
REQ-018 The sign of q SHALL be sign(N) XOR sign(D), applied after the magnitude division.
REQ-019 q SHALL saturate to [-32768, +32767].
REQ-020 When D=0: c SHALL be +32767 if N>0, -32768 if N<0, and 0 if N=0.
REQ-021 The FINISH state SHALL update all LANES elements of c and assert ready=1 at edge E0+25, then return to IDLE.
REQ-022 ready SHALL deassert at E0+26; total latency is 25 cycles.
REQ-023 The earliest next acceptance SHALL be E0+26; if valid is held high, the module SHALL restart back-to-back (throughput one result per 26 cycles).
REQ-024 valid asserted during DIVIDE or FINISH SHALL be ignored (no queueing).
REQ-025 All lanes SHALL operate in lockstep and finish on the same cycle.

Reset
REQ-026 Asserting reset SHALL immediately force state IDLE, ready=0, c[all]=0, the iteration counter to 0 and the lane registers to 0.
REQ-027 Reset asserted mid-operation SHALL abort the operation with no ready pulse; the first acceptance is the first rising edge with reset low, IDLE and valid=1.

Structure
REQ-028 A shared package vector_division_pkg SHALL hold LANES, WIDTH, FRAC, ITER=24 and the state enum type {IDLE, DIVIDE, FINISH}.
REQ-029 One sub-module, sdiv_lane, SHALL implement the per-lane numerator/denominator select, the restoring iteration, sign fix-up, saturation and the divide-by-zero rule; it SHALL be instantiated LANES times under a single shared FSM/counter in vector_division.

Verification
REQ-030 sel=1, a={100,200,300,400}, b={110,210,310,410}, valid=1 after reset -> ready pulse 25 cycles after acceptance, c={25,12,8,6}.
REQ-031 sel=0 with the same a and b -> c={232,243,247,249}.
REQ-032 sel=0, a={-512,512,-512,0}, b={256,-256,-256,7} -> c={-512,-512,512,0}.
REQ-033 sel=0, a={32767,-32768,5,-5}, b={1,1,0,0} -> c={32767,-32768,32767,-32768}.
REQ-034 valid held high continuously -> ready pulses every 26 cycles and c stays stable between pulses.
REQ-035 reset asserted at cycle 10 of DIVIDE -> no ready pulse and c=0; a new request after reset release completes normally with correct values.
